// File: rtl/sample_stream_packer.sv
// -----------------------------------------------------------------------------
// sample_stream_packer
//
// Serialises each captured sample beat into a variable-length frame of
// DATA_BITS-wide words on a valid/ready stream:
//   word 0 : {zero pad, diff_bitset}
//   word 1 : delta (uncaptured in_valid beats since the previous capture)
//   word 2+: changed samples, lowest channel index first
// A two-entry frame buffer (active + pending) absorbs back-pressure; a beat
// that finds both entries occupied is dropped and flagged on `overflow`.
//
// Ports:
//   clk             clock
//   rst             synchronous reset, active-high
//   in_valid        a sample beat is present (no upstream stall possible)
//   diff_bitset     changed-channel mask, bit j = channel j
//   data_compressed left-packed samples, word 0 = highest changed channel
//   out_data        stream word
//   out_valid       out_data is valid
//   out_ready       downstream accepts the word
//   out_last        final word of a frame
//   overflow        sticky drop flag
//   overflow_clr    clears overflow (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module sample_stream_packer #(
    parameter int CHANNEL   = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [CHANNEL-1:0]             diff_bitset,
    input  logic [DATA_BITS*CHANNEL-1:0]   data_compressed,
    output logic [DATA_BITS-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           overflow,
    input  logic                           overflow_clr
);

    // Word index and popcount both need to reach CHANNEL+1.
    localparam int CW = $clog2(CHANNEL + 2);
    localparam logic [DATA_BITS-1:0] DELTA_MAX = {DATA_BITS{1'b1}};

    // Number of set bits in a channel mask.
    function automatic logic [CW-1:0] popcount(input logic [CHANNEL-1:0] bits);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < CHANNEL; i++) begin
            cnt = cnt + CW'(bits[i]);
        end
        return cnt;
    endfunction

    // Word `idx` of a frame; samples go out from packed word cnt-1 down to 0.
    function automatic logic [DATA_BITS-1:0] frame_word(
        input logic [CHANNEL-1:0]           bits,
        input logic [DATA_BITS-1:0]         delta,
        input logic [DATA_BITS*CHANNEL-1:0] data,
        input logic [CW-1:0]                cnt,
        input logic [CW-1:0]                idx
    );
        logic [DATA_BITS-1:0] word;
        logic [CW-1:0]        sel;
        word = {DATA_BITS{1'b0}};
        sel  = cnt + CW'(1) - idx;
        if (idx == CW'(0)) begin
            word[CHANNEL-1:0] = bits;
        end else if (idx == CW'(1)) begin
            word = delta;
        end else begin
            word = data[int'(sel)*DATA_BITS +: DATA_BITS];
        end
        return word;
    endfunction

    // Active frame (being emitted)
    logic                           act_vld_q,   act_vld_d;
    logic [CHANNEL-1:0]             act_bits_q,  act_bits_d;
    logic [DATA_BITS-1:0]           act_delta_q, act_delta_d;
    logic [DATA_BITS*CHANNEL-1:0]   act_data_q,  act_data_d;
    logic [CW-1:0]                  act_cnt_q,   act_cnt_d;
    logic [CW-1:0]                  act_idx_q,   act_idx_d;
    // Pending frame
    logic                           pnd_vld_q,   pnd_vld_d;
    logic [CHANNEL-1:0]             pnd_bits_q,  pnd_bits_d;
    logic [DATA_BITS-1:0]           pnd_delta_q, pnd_delta_d;
    logic [DATA_BITS*CHANNEL-1:0]   pnd_data_q,  pnd_data_d;
    logic [CW-1:0]                  pnd_cnt_q,   pnd_cnt_d;
    // Delta counter, sticky flag and registered stream outputs
    logic [DATA_BITS-1:0]           delta_q,     delta_d;
    logic                           ovf_q,       ovf_d;
    logic [DATA_BITS-1:0]           out_data_q,  out_data_d;
    logic                           out_last_q,  out_last_d;

    logic                           capturable_s;
    logic                           drop_s;
    logic                           fire_s;

    // Next-state: retire, promote, then capture/drop, then pre-compute outputs.
    always_comb begin
        act_vld_d   = act_vld_q;
        act_bits_d  = act_bits_q;
        act_delta_d = act_delta_q;
        act_data_d  = act_data_q;
        act_cnt_d   = act_cnt_q;
        act_idx_d   = act_idx_q;
        pnd_vld_d   = pnd_vld_q;
        pnd_bits_d  = pnd_bits_q;
        pnd_delta_d = pnd_delta_q;
        pnd_data_d  = pnd_data_q;
        pnd_cnt_d   = pnd_cnt_q;
        delta_d     = delta_q;
        drop_s      = 1'b0;

        fire_s       = act_vld_q & out_ready;
        // A saturated delta forces an (empty) frame so the counter never wraps.
        capturable_s = in_valid & ((|diff_bitset) | (delta_q == DELTA_MAX));

        // Retire or advance the active frame.
        if (fire_s && out_last_q) begin
            act_vld_d = 1'b0;
        end else if (fire_s) begin
            act_idx_d = act_idx_q + CW'(1);
        end else begin
            act_idx_d = act_idx_q;
        end

        // Promote pending into a freshly emptied active slot.
        if (!act_vld_d && pnd_vld_q) begin
            act_vld_d   = 1'b1;
            act_bits_d  = pnd_bits_q;
            act_delta_d = pnd_delta_q;
            act_data_d  = pnd_data_q;
            act_cnt_d   = pnd_cnt_q;
            act_idx_d   = {CW{1'b0}};
            pnd_vld_d   = 1'b0;
        end else begin
            pnd_vld_d   = pnd_vld_q;
        end

        // Capture the beat, drop it, or just count it.
        if (capturable_s && !act_vld_d) begin
            act_vld_d   = 1'b1;
            act_bits_d  = diff_bitset;
            act_delta_d = delta_q;
            act_data_d  = data_compressed;
            act_cnt_d   = popcount(diff_bitset);
            act_idx_d   = {CW{1'b0}};
            delta_d     = {DATA_BITS{1'b0}};
        end else if (capturable_s && !pnd_vld_d) begin
            pnd_vld_d   = 1'b1;
            pnd_bits_d  = diff_bitset;
            pnd_delta_d = delta_q;
            pnd_data_d  = data_compressed;
            pnd_cnt_d   = popcount(diff_bitset);
            delta_d     = {DATA_BITS{1'b0}};
        end else if (capturable_s) begin
            drop_s  = 1'b1;
            delta_d = (delta_q == DELTA_MAX) ? delta_q : delta_q + DATA_BITS'(1);
        end else if (in_valid) begin
            delta_d = delta_q + DATA_BITS'(1);
        end else begin
            delta_d = delta_q;
        end

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (act_vld_d) begin
            out_data_d = frame_word(act_bits_d, act_delta_d, act_data_d, act_cnt_d, act_idx_d);
            out_last_d = (act_idx_d == act_cnt_d + CW'(1));
        end else begin
            out_data_d = {DATA_BITS{1'b0}};
            out_last_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_vld_q   <= 1'b0;
            act_bits_q  <= {CHANNEL{1'b0}};
            act_delta_q <= {DATA_BITS{1'b0}};
            act_data_q  <= {(DATA_BITS*CHANNEL){1'b0}};
            act_cnt_q   <= {CW{1'b0}};
            act_idx_q   <= {CW{1'b0}};
            pnd_vld_q   <= 1'b0;
            pnd_bits_q  <= {CHANNEL{1'b0}};
            pnd_delta_q <= {DATA_BITS{1'b0}};
            pnd_data_q  <= {(DATA_BITS*CHANNEL){1'b0}};
            pnd_cnt_q   <= {CW{1'b0}};
            delta_q     <= {DATA_BITS{1'b0}};
            ovf_q       <= 1'b0;
            out_data_q  <= {DATA_BITS{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            act_vld_q   <= act_vld_d;
            act_bits_q  <= act_bits_d;
            act_delta_q <= act_delta_d;
            act_data_q  <= act_data_d;
            act_cnt_q   <= act_cnt_d;
            act_idx_q   <= act_idx_d;
            pnd_vld_q   <= pnd_vld_d;
            pnd_bits_q  <= pnd_bits_d;
            pnd_delta_q <= pnd_delta_d;
            pnd_data_q  <= pnd_data_d;
            pnd_cnt_q   <= pnd_cnt_d;
            delta_q     <= delta_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = act_vld_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/sample_stream_packer.md
Name: sample_stream_packer

Overview:
- Sits directly downstream of the sample compression stage.
- Each sample beat it consumes the changed-channel bitset and the left-packed compressed sample words.
- It serialises every beat with a non-zero bitset into a variable-length frame of DATA_BITS-wide words: header, time delta, then the changed samples. Frames go out on a valid/ready stream toward the capture FIFO/host link.
- A two-frame buffer (active + pending) absorbs output back-pressure; beats that cannot be buffered are dropped and flagged.

Parameters:
- CHANNEL, 8, number of sampled channels; must be ≤ DATA_BITS.
- DATA_BITS, 16, width of one sample word, of the output word and of the delta counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  one sample beat is present this cycle. The upstream stage cannot stall, so there is no ready.
- diff_bitset  in  CHANNEL  bit j=1 means channel j changed.
- data_compressed  in  DATA_BITS*CHANNEL  word 0 = highest-index changed channel; words popcount-1..0 are valid; the rest are don't-care.
- out_data  out  DATA_BITS  stream word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  marks the final word of a frame.
- overflow  out  1  sticky; a beat was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Frame format, in emission order:
  - word 0 = {zero pad, diff_bitset}
  - word 1 = delta
  - then the changed samples, lowest channel index first, i.e. data_compressed words popcount-1 down to 0.
  - Frame length = 2 + popcount(diff_bitset); out_last is high on the final word only.
- Capturable beat: in_valid=1 and either diff_bitset≠0, or delta counter = 2^DATA_BITS-1.
  - The second case produces an empty frame: bitset 0, delta all-ones, length 2, out_last on word 1.
- Delta counter:
  - Counts in_valid beats that are not captured: zero-bitset beats and dropped beats.
  - On a captured beat, its current value is latched into the frame and the counter is reset to 0 on the same edge.
  - Reset value 0; never wraps, because saturation forces an empty frame.
- Buffering: active (frame being emitted) and pending (one frame). Each edge is evaluated in this order:
  1. If out_valid & out_ready & out_last, active becomes empty.
  2. If active is empty and pending is full, pending moves to active.
  3. A capturable beat loads active if it is still empty, else pending if it is empty. Otherwise the beat is dropped: overflow←1 and the delta counter increments.
- Latency: a beat captured into an empty active at edge t drives word 0 with out_valid=1 in cycle t+1.
  - Back-to-back frames with out_ready held high have no idle cycle between them.
- Handshake:
  - A word advances only when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid=0 only when active is empty.
- Word index counter inside active: runs 0..1+popcount and resets on load.
  - popcount is computed at capture and stored with the frame.
- overflow:
  - Set on a drop; cleared by overflow_clr.
  - A drop in the same cycle as overflow_clr wins, so overflow=1.
- Reset values: out_valid=0, out_last=0, out_data=0, overflow=0, delta=0, both buffers empty.
  - Reset mid-frame abandons the frame; no out_last is emitted and the partial frame is not resumed.
- Zero-bitset beats that are not saturating produce no output.

Test Plan:
- Single frame: reset, 3 zero beats, then bitset 8'b0000_0101 with compressed words w0=0xBBBB (ch2), w1=0xAAAA (ch0); out_ready=1 → stream 0x0005, 0x0003, 0xAAAA, 0xBBBB; out_last on 0xBBBB; word 0 appears the cycle after capture.
- Back-pressure: same frame, out_ready toggled 1,0,0,1,... → every word is held stable while stalled, no word is duplicated or skipped, frame content is identical.
- Overflow: out_ready=0, bitset 0x01 on 3 consecutive beats → first two frames buffered, third dropped, overflow=1; releasing out_ready emits two frames, the second with delta 0. The next captured frame's delta includes the dropped beat. overflow_clr → 0.
- Saturation: DATA_BITS=4, all beats zero → after 15 zero beats, the 16th beat emits an empty frame 0x0, 0xF (out_last on 0xF); the counter restarts at 0.
- Full bitset, back-to-back: bitset 0xFF every beat with out_ready=1 → 10-word frames emitted contiguously; drops begin once the buffer fills (input rate > output rate) and overflow sets.
- Reset mid-frame: assert rst during word 2 of a frame → out_valid=0 next cycle, no out_last; the next frame starts cleanly with a delta counted from reset.
